// File: rtl/cpu_pkg.sv
// Shared encodings for the micro-coded CPU control path: opcodes, step indices,
// sequencer states and the control-word layout.
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [2:0] STEP_T0      = 3'd0;
    localparam logic [2:0] STEP_T1      = 3'd1;
    localparam logic [2:0] STEP_T2      = 3'd2;
    localparam logic [2:0] STEP_T3      = 3'd3;
    localparam logic [2:0] STEP_T4      = 3'd4;
    localparam logic [2:0] STEP_INVALID = 3'd7;

    localparam logic [1:0] ST_RUN_ENC  = 2'b01;
    localparam logic [1:0] ST_HALT_ENC = 2'b10;

    typedef enum logic [1:0] {
        S_RUN  = ST_RUN_ENC,
        S_HALT = ST_HALT_ENC
    } state_e;

    typedef struct packed {
        logic pc_enable;
        logic mem_enable;
        logic ir_enable;
        logic a_enable;
        logic alu_enable;
        logic mar_latch;
        logic mem_latch;
        logic ir_latch;
        logic a_latch;
        logic b_latch;
        logic out_latch;
        logic pc_latch;
        logic flags_latch;
        logic pc_increment;
        logic alu_subtract;
    } ctrl_t;

    // Final micro-step of each opcode; undefined opcodes behave like NOP.
    function automatic logic [2:0] last_step(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA: last_step = STEP_T3;
            OP_ADD, OP_SUB: last_step = STEP_T4;
            default:        last_step = STEP_T2;
        endcase
    endfunction

endpackage

// File: rtl/control_rom.sv
// Combinational decode of (state, step, opcode, flags, run) into the control word.
module control_rom
    import cpu_pkg::*;
(
    input  state_e     state_i,
    input  logic [2:0] step_i,
    input  logic [3:0] opcode_i,
    input  logic       flag_carry_i,
    input  logic       flag_zero_i,
    input  logic       run_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        if (state_i == S_RUN) begin
            case (step_i)
                STEP_T0: begin
                    if (run_i) begin
                        ctrl_o.pc_enable = 1'b1;
                        ctrl_o.mar_latch = 1'b1;
                    end
                end
                STEP_T1: begin
                    ctrl_o.mem_enable   = 1'b1;
                    ctrl_o.ir_latch     = 1'b1;
                    ctrl_o.pc_increment = 1'b1;
                end
                STEP_T2: begin
                    case (opcode_i)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ctrl_o.ir_enable = 1'b1;
                            ctrl_o.mar_latch = 1'b1;
                        end
                        OP_LDI: begin
                            ctrl_o.ir_enable = 1'b1;
                            ctrl_o.a_latch   = 1'b1;
                        end
                        OP_JMP: begin
                            ctrl_o.ir_enable = 1'b1;
                            ctrl_o.pc_latch  = 1'b1;
                        end
                        OP_JC: begin
                            ctrl_o.ir_enable = flag_carry_i;
                            ctrl_o.pc_latch  = flag_carry_i;
                        end
                        OP_JZ: begin
                            ctrl_o.ir_enable = flag_zero_i;
                            ctrl_o.pc_latch  = flag_zero_i;
                        end
                        OP_OUT: begin
                            ctrl_o.a_enable  = 1'b1;
                            ctrl_o.out_latch = 1'b1;
                        end
                        default: ;
                    endcase
                end
                STEP_T3: begin
                    case (opcode_i)
                        OP_LDA: begin
                            ctrl_o.mem_enable = 1'b1;
                            ctrl_o.a_latch    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ctrl_o.mem_enable = 1'b1;
                            ctrl_o.b_latch    = 1'b1;
                        end
                        OP_STA: begin
                            ctrl_o.a_enable  = 1'b1;
                            ctrl_o.mem_latch = 1'b1;
                        end
                        default: ;
                    endcase
                end
                STEP_T4: begin
                    if (opcode_i == OP_ADD || opcode_i == OP_SUB) begin
                        ctrl_o.alu_enable   = 1'b1;
                        ctrl_o.a_latch      = 1'b1;
                        ctrl_o.flags_latch  = 1'b1;
                        ctrl_o.alu_subtract = (opcode_i == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Step counter and RUN/HALT state for the CPU control path; decode lives in control_rom.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned STEP_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic [3:0]            opcode,
    input  logic                  flag_carry,
    input  logic                  flag_zero,
    output logic                  pc_enable,
    output logic                  mem_enable,
    output logic                  ir_enable,
    output logic                  a_enable,
    output logic                  alu_enable,
    output logic                  mar_latch,
    output logic                  mem_latch,
    output logic                  ir_latch,
    output logic                  a_latch,
    output logic                  b_latch,
    output logic                  out_latch,
    output logic                  pc_latch,
    output logic                  flags_latch,
    output logic                  pc_increment,
    output logic                  alu_subtract,
    output logic                  halted,
    output logic [STEP_WIDTH-1:0] step
);

    state_e                state_q, state_d;
    logic [STEP_WIDTH-1:0] step_q, step_d;
    logic [2:0]            step_idx;
    ctrl_t                 rom_ctrl;
    ctrl_t                 ctrl;

    // Out-of-range counts decode as an invalid index so the ROM emits nothing.
    assign step_idx = (step_q > STEP_WIDTH'(STEP_T4)) ? STEP_INVALID : step_q[2:0];

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        case (state_q)
            S_RUN: begin
                case (step_idx)
                    STEP_T0: step_d = run ? STEP_WIDTH'(STEP_T1) : '0;
                    STEP_T1: step_d = STEP_WIDTH'(STEP_T2);
                    STEP_T2: begin
                        if (opcode == OP_HLT) begin
                            state_d = S_HALT;
                            step_d  = '0;
                        end else if (last_step(opcode) == STEP_T2) begin
                            step_d = '0;
                        end else begin
                            step_d = STEP_WIDTH'(STEP_T3);
                        end
                    end
                    STEP_T3: step_d = (last_step(opcode) == STEP_T3) ? '0 : STEP_WIDTH'(STEP_T4);
                    default: step_d = '0;
                endcase
            end
            S_HALT: step_d = '0;
            default: begin
                state_d = S_RUN;
                step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_RUN;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    control_rom u_rom (
        .state_i      (state_q),
        .step_i       (step_idx),
        .opcode_i     (opcode),
        .flag_carry_i (flag_carry),
        .flag_zero_i  (flag_zero),
        .run_i        (run),
        .ctrl_o       (rom_ctrl)
    );

    // T0 decode is combinational in run, so reset must mask it directly.
    assign ctrl = reset ? ctrl_t'('0) : rom_ctrl;

    assign pc_enable    = ctrl.pc_enable;
    assign mem_enable   = ctrl.mem_enable;
    assign ir_enable    = ctrl.ir_enable;
    assign a_enable     = ctrl.a_enable;
    assign alu_enable   = ctrl.alu_enable;
    assign mar_latch    = ctrl.mar_latch;
    assign mem_latch    = ctrl.mem_latch;
    assign ir_latch     = ctrl.ir_latch;
    assign a_latch      = ctrl.a_latch;
    assign b_latch      = ctrl.b_latch;
    assign out_latch    = ctrl.out_latch;
    assign pc_latch     = ctrl.pc_latch;
    assign flags_latch  = ctrl.flags_latch;
    assign pc_increment = ctrl.pc_increment;
    assign alu_subtract = ctrl.alu_subtract;
    assign halted       = (state_q == S_HALT) && !reset;
    assign step         = step_q;

endmodule
